// File: rtl/ram_access_pkg.sv
// Shared types for the RAM access sequencer: FSM states, request record, width defaults.
// Optional statistics outputs are enabled by defining RAM_ACCESS_STATS_EN.
package ram_access_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_SETUP  = 3'd1,
        ST_W_STROBE = 3'd2,
        ST_W_HOLD   = 3'd3,
        ST_R_ADDR   = 3'd4,
        ST_R_SAMPLE = 3'd5
    } ram_state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } ram_req_t;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int depth_log2(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_access_fifo.sv
// In-order request FIFO with full/empty/count; read data is the head entry (fall-through).
// Pushes while full and pops while empty are ignored; simultaneous push/pop keeps the count.
module ram_access_fifo
    import ram_access_pkg::*;
#(
    parameter type T          = ram_req_t,
    parameter int  DEPTH      = 4,
    localparam int PW         = depth_log2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  T            push_dat_i,
    input  logic        pop_i,
    output T            pop_dat_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [PW:0] count_o
);

    localparam int          CW       = PW + 1;
    localparam logic [PW:0] FULL_CNT = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && (count_q != FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences queued read/write requests onto the RAM pins with setup/strobe/hold phasing.
// Writes take 4 cycles, reads 3; define RAM_ACCESS_STATS_EN for wr_count/rd_count outputs.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wr,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
`ifdef RAM_ACCESS_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam int PW = depth_log2(FIFO_DEPTH);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_rec_t;

    req_rec_t          push_rec;
    req_rec_t          head_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW:0]       fifo_count;
    logic              pop;

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_oe_q, ram_oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign push_rec = '{we: req_we, addr: req_addr, wdata: req_wdata};

    ram_access_fifo #(
        .T     (req_rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (req_valid),
        .push_dat_i (push_rec),
        .pop_i      (pop),
        .pop_dat_o  (head_rec),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ram_a_d     = ram_a_q;
        ram_din_d   = ram_din_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    ram_a_d   = head_rec.addr;
                    ram_din_d = head_rec.wdata;
                    state_d   = head_rec.we ? ST_W_SETUP : ST_R_ADDR;
                end
            end
            ST_W_SETUP:  state_d = ST_W_STROBE;
            ST_W_STROBE: state_d = ST_W_HOLD;
            ST_W_HOLD:   state_d = ST_IDLE;
            ST_R_ADDR:   state_d = ST_R_SAMPLE;
            ST_R_SAMPLE: begin
                // RAM output has been enabled for two cycles; capture on exit.
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_dout;
            end
            default:     state_d = ST_IDLE;
        endcase

        // Pin strobes are registered from the state being entered.
        ram_wr_d = (state_d == ST_W_STROBE);
        ram_oe_d = (state_d == ST_R_ADDR) || (state_d == ST_R_SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ram_a_q     <= '0;
            ram_din_q   <= '0;
            ram_wr_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_a_q     <= ram_a_d;
            ram_din_q   <= ram_din_d;
            ram_wr_q    <= ram_wr_d;
            ram_oe_q    <= ram_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_din   = ram_din_q;
    assign ram_wr    = ram_wr_q;
    assign ram_oe    = ram_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign req_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

`ifdef RAM_ACCESS_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    // W_STROBE and R_SAMPLE each have a single predecessor, so state_d marks entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if ((state_d == ST_W_STROBE) && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if ((state_d == ST_R_SAMPLE) && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural RAM, in-order scoreboard, directed and random requests.
// Statistics checks are compiled in when RAM_ACCESS_STATS_EN is defined.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  ram_a;
    logic [15:0] ram_din;
    logic        ram_wr;
    logic        ram_oe;
    logic [15:0] ram_dout;
    logic        busy;
`ifdef RAM_ACCESS_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] rd_count;
`endif

    always #5 clk = ~clk;

    ram_access_ctrl #(
        .ADDR_W     (8),
        .DATA_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_a     (ram_a),
        .ram_din   (ram_din),
        .ram_wr    (ram_wr),
        .ram_oe    (ram_oe),
        .ram_dout  (ram_dout),
        .busy      (busy)
`ifdef RAM_ACCESS_STATS_EN
        ,
        .wr_count  (wr_count),
        .rd_count  (rd_count)
`endif
    );

    // Behavioural RAM (bench side) and the reference memory of the model.
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    assign ram_dout = mem[ram_a];

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr [$];
    logic [15:0] exp_rd [$];
    int          rsp_cyc [$];

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          wr_pulses = 0;
    int          rsp_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        prev_rsp = 1'b0;
    logic        prev_rst = 1'b1;
    logic [7:0]  prev_a = '0;
    logic [15:0] prev_din = '0;
    logic        accepted = 1'b0;
    logic        saw_stall = 1'b0;
    logic        wr_pend = 1'b0;
    logic [7:0]  wr_pa = '0;
    logic [15:0] wr_pd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation at the falling edge: protocol rules, scoreboard, accept tracking.
    task automatic monitor();
        wr_t e;
        cyc_n++;
        if (ram_wr) begin
            wr_pend = 1'b1;
            wr_pa   = ram_a;
            wr_pd   = ram_din;
        end
        if (!reset) begin
            check("wr_oe_exclusive", {31'd0, ram_wr & ram_oe}, 32'd0);
            if (ram_wr) begin
                wr_pulses++;
                check("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
                if (!prev_rst) begin
                    check("a_setup", {24'd0, ram_a}, {24'd0, prev_a});
                    check("din_setup", {16'd0, ram_din}, {16'd0, prev_din});
                end
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr_order", {24'd0, ram_a}, {24'd0, e.a});
                    check("wr_data_order", {16'd0, ram_din}, {16'd0, e.d});
                end
            end
            if (prev_wr && !prev_rst) begin
                check("a_hold", {24'd0, ram_a}, {24'd0, prev_a});
                check("din_hold", {16'd0, ram_din}, {16'd0, prev_din});
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc.push_back(cyc_n);
                check("rsp_single_pulse", {31'd0, prev_rsp}, 32'd0);
                if (exp_rd.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rd.pop_front()});
                end
            end
            if (req_valid && !req_ready) begin
                saw_stall = 1'b1;
            end
            if (req_valid && req_ready) begin
                accepted = 1'b1;
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                    exp_wr.push_back('{a: req_addr, d: req_wdata});
                end else begin
                    exp_rd.push_back(ref_mem[req_addr]);
                end
            end
        end
        prev_wr  = ram_wr;
        prev_rsp = rsp_valid;
        prev_rst = reset;
        prev_a   = ram_a;
        prev_din = ram_din;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (wr_pend) begin
            mem[wr_pa] = wr_pd;
            wr_pend    = 1'b0;
        end
    endtask

    task automatic send(input logic we, input logic [7:0] a, input logic [15:0] d);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        accepted  = 1'b0;
        n = 0;
        while (!accepted && n < 40) begin
            cyc();
            n++;
        end
        check("accept_timeout", {31'd0, accepted}, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy || exp_rd.size() != 0) && n < limit) begin
            cyc();
            n++;
        end
        check("drain_reads", exp_rd.size(), 32'd0);
        check("drain_writes", exp_wr.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
    endtask

    initial begin
        logic        wr_s [6];
        logic [7:0]  a_s  [6];
        logic [15:0] d_s  [6];
        int          wr_idx;
        int          first_oe;
        int          base;
        int          rb;
        int          n;
        logic [7:0]  ra;
        logic [15:0] rd;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 3 + 7);
            ref_mem[i] = 16'(i * 3 + 7);
        end

        do_reset();
        check("rst_ram_a", {24'd0, ram_a}, 32'd0);
        check("rst_ram_din", {16'd0, ram_din}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_oe", {31'd0, ram_oe}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Single write: sample pins for six cycles after the accept edge.
        send(1'b1, 8'h3C, 16'hA5A5);
        for (int i = 0; i < 6; i++) begin
            wr_s[i] = ram_wr;
            a_s[i]  = ram_a;
            d_s[i]  = ram_din;
            cyc();
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("w1_wr_%0d", i), {31'd0, wr_s[i]}, {31'd0, (i == 2)});
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("w1_a_%0d", i), {24'd0, a_s[i]}, 32'h3C);
            check($sformatf("w1_din_%0d", i), {16'd0, d_s[i]}, 32'hA5A5);
        end
        wait_idle(40);

        // Write then read-back of the same address.
        rb = rsp_cnt;
        send(1'b1, 8'h05, 16'h1234);
        send(1'b0, 8'h05, 16'h0000);
        wr_idx   = -1;
        first_oe = -1;
        for (int i = 0; i < 16; i++) begin
            if (ram_wr) wr_idx = i;
            if (ram_oe && first_oe < 0) first_oe = i;
            cyc();
        end
        check("raw_oe_after_hold", {31'd0, (wr_idx >= 0) && (first_oe >= wr_idx + 2)}, 32'd1);
        wait_idle(40);
        check("raw_rsp_count", rsp_cnt - rb, 32'd1);
        check("raw_rdata", {16'd0, rsp_rdata}, 32'h1234);

        // Burst of writes: FIFO plus one request in flight, so the sixth must stall.
        saw_stall = 1'b0;
        base = wr_pulses;
        for (int k = 0; k < 6; k++) begin
            send(1'b1, 8'(8'h40 + k), 16'($urandom));
        end
        check("burst_stall_seen", {31'd0, saw_stall}, 32'd1);
        n = 0;
        while (wr_pulses < base + 6 && n < 100) begin
            cyc();
            n++;
        end
        check("burst_all_written", wr_pulses - base, 32'd6);
        check("burst_busy_in_hold", {31'd0, busy}, 32'd1);
        cyc();
        check("burst_busy_after", {31'd0, busy}, 32'd0);
        wait_idle(40);

        // Reset while the strobe is high drops everything queued.
        rb = rsp_cnt;
        send(1'b1, 8'h77, 16'hBEEF);
        send(1'b0, 8'h10, 16'h0000);
        send(1'b0, 8'h11, 16'h0000);
        n = 0;
        while (!ram_wr && n < 20) begin
            cyc();
            n++;
        end
        check("rst_strobe_found", {31'd0, ram_wr}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        check("midrst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("midrst_ram_oe", {31'd0, ram_oe}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (12) cyc();
        check("midrst_no_rsp", rsp_cnt - rb, 32'd0);

        // Reads at both address extremes, back to back.
        mem[8'h00] = 16'h0001;  ref_mem[8'h00] = 16'h0001;
        mem[8'hFF] = 16'hFFFF;  ref_mem[8'hFF] = 16'hFFFF;
        rb = rsp_cyc.size();
        send(1'b0, 8'h00, 16'h0000);
        send(1'b0, 8'hFF, 16'h0000);
        wait_idle(60);
        check("edge_rsp_count", rsp_cyc.size() - rb, 32'd2);
        if (rsp_cyc.size() >= rb + 2) begin
            check("edge_rsp_spacing", rsp_cyc[rb + 1] - rsp_cyc[rb], 32'd3);
        end
        check("edge_last_rdata", {16'd0, rsp_rdata}, 32'hFFFF);

        // Random mix against the reference memory and in-order scoreboard.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) cyc();
            end
            case ($urandom_range(0, 3))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                2:       ra = 8'($urandom_range(0, 7));
                default: ra = 8'($urandom_range(0, 255));
            endcase
            rd = 16'($urandom);
            send(1'($urandom_range(0, 1)), ra, rd);
        end
        wait_idle(400);

`ifdef RAM_ACCESS_STATS_EN
        do_reset();
        check("stats_rst_wr", {16'd0, wr_count}, 32'd0);
        check("stats_rst_rd", {16'd0, rd_count}, 32'd0);
        for (int k = 0; k < 3; k++) send(1'b1, 8'(8'h20 + k), 16'(16'h100 + k));
        for (int k = 0; k < 2; k++) send(1'b0, 8'(8'h20 + k), 16'h0000);
        wait_idle(80);
        check("stats_wr_count", {16'd0, wr_count}, 32'd3);
        check("stats_rd_count", {16'd0, rd_count}, 32'd2);
        do_reset();
        check("stats_clr_wr", {16'd0, wr_count}, 32'd0);
        check("stats_clr_rd", {16'd0, rd_count}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
